// File: rtl/ball_ctrl_pkg.sv
// Shared screen geometry, colours and ball FSM states for the paddle game.
package pong_pkg;

    localparam int MAX_X         = 640;
    localparam int MAX_Y         = 480;
    localparam int PADDLE_WIDTH  = 100;
    localparam int PADDLE_HEIGHT = 10;

    localparam logic [11:0] COLOR_WHITE = 12'hFFF;
    localparam logic [11:0] COLOR_BLACK = 12'h000;
    localparam logic [11:0] COLOR_RED   = 12'hF00;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        MOVE  = 2'd1,
        OVER  = 2'd2
    } ball_state_t;

    // True when pos lies in [lo, lo+size); 11-bit math so lo+size cannot wrap.
    function automatic logic in_span(input logic [9:0] pos, input logic [9:0] lo,
                                     input logic [10:0] size);
        logic [10:0] pos_w;
        logic [10:0] lo_w;
        pos_w = {1'b0, pos};
        lo_w  = {1'b0, lo};
        return (pos_w >= lo_w) && (pos_w < (lo_w + size));
    endfunction

endpackage

// File: rtl/ball_ctrl_if.sv
// Ball block bus: pixel/paddle/control inputs and ball state outputs.
interface ball_ctrl_if;
    logic        refr_tick;
    logic        launch;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [9:0]  paddle_x;
    logic [9:0]  paddle_y;
    logic [11:0] ball_rgb;
    logic        ball_on;
    logic [9:0]  ball_x;
    logic [9:0]  ball_y;
    logic        miss;
    logic [1:0]  lives;
    logic        game_over;

    modport master (
        output refr_tick, launch, x, y, paddle_x, paddle_y,
        input  ball_rgb, ball_on, ball_x, ball_y, miss, lives, game_over
    );

    modport slave (
        input  refr_tick, launch, x, y, paddle_x, paddle_y,
        output ball_rgb, ball_on, ball_x, ball_y, miss, lives, game_over
    );
endinterface

// File: rtl/ball_ctrl_step_calc.sv
// Combinational next position/direction of the ball for one motion tick,
// including wall bounces, paddle hit and bottom-edge miss detection.
module ball_step_calc
    import pong_pkg::*;
#(
    parameter int BALL_SIZE = 8
) (
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic       dx,
    input  logic       dy,
    input  logic [9:0] paddle_x,
    input  logic [9:0] paddle_y,
    input  logic [2:0] step,
    output logic [9:0] nxt_x,
    output logic [9:0] nxt_y,
    output logic       nxt_dx,
    output logic       nxt_dy,
    output logic       hit,
    output logic       miss
);
    localparam logic [10:0] SIZE  = 11'(BALL_SIZE);
    localparam logic [10:0] X_LIM = 11'(MAX_X - BALL_SIZE);
    localparam logic [10:0] Y_LIM = 11'(MAX_Y - BALL_SIZE);
    localparam logic [10:0] PW    = 11'(PADDLE_WIDTH);
    localparam logic [10:0] PH    = 11'(PADDLE_HEIGHT);

    logic [10:0] bx_s, by_s, px_s, py_s, st_s;
    logic [10:0] x_inc_s, x_dec_s, y_inc_s, y_dec_s;
    logic [10:0] bx_end_s, by_end_s, px_end_s, py_end_s, rest_y_s;
    logic        unused_msb_s;

    assign bx_s     = {1'b0, ball_x};
    assign by_s     = {1'b0, ball_y};
    assign px_s     = {1'b0, paddle_x};
    assign py_s     = {1'b0, paddle_y};
    assign st_s     = {8'd0, step};
    assign x_inc_s  = bx_s + st_s;
    assign x_dec_s  = bx_s - st_s;
    assign y_inc_s  = by_s + st_s;
    assign y_dec_s  = by_s - st_s;
    assign bx_end_s = bx_s + SIZE;
    assign by_end_s = by_s + SIZE;
    assign px_end_s = px_s + PW;
    assign py_end_s = py_s + PH;
    assign rest_y_s = py_s - SIZE;

    // Paddle check only applies while falling and outranks the bottom-edge check.
    assign hit  = dy && (by_end_s >= py_s) && (by_end_s <= py_end_s)
                     && (bx_end_s > px_s) && (bx_s < px_end_s);
    assign miss = dy && !hit && (by_s >= Y_LIM);

    assign unused_msb_s = &{1'b0, x_inc_s[10], x_dec_s[10], y_inc_s[10],
                            y_dec_s[10], rest_y_s[10]};

    // Horizontal axis: clamp against the left/right walls and reverse.
    always_comb begin
        nxt_x  = ball_x;
        nxt_dx = dx;
        if (dx) begin
            if (bx_s >= (X_LIM - st_s)) begin
                nxt_x  = X_LIM[9:0];
                nxt_dx = 1'b0;
            end else begin
                nxt_x  = x_inc_s[9:0];
            end
        end else begin
            if (bx_s <= st_s) begin
                nxt_x  = 10'd0;
                nxt_dx = 1'b1;
            end else begin
                nxt_x  = x_dec_s[9:0];
            end
        end
    end

    // Vertical axis: top wall bounce, paddle rest position, or fall.
    always_comb begin
        nxt_y  = ball_y;
        nxt_dy = dy;
        if (!dy) begin
            if (by_s <= st_s) begin
                nxt_y  = 10'd0;
                nxt_dy = 1'b1;
            end else begin
                nxt_y  = y_dec_s[9:0];
            end
        end else if (hit) begin
            nxt_y  = rest_y_s[9:0];
            nxt_dy = 1'b0;
        end else if (miss) begin
            nxt_y  = ball_y;
        end else begin
            nxt_y  = y_inc_s[9:0];
        end
    end
endmodule

// File: rtl/ball_ctrl.sv
// Ball object: serve/move/game-over FSM, lives counter and pixel generation.
// Optional BALL_SPEEDUP_EN raises the step every fourth paddle hit (max 4).
module ball_ctrl
    import pong_pkg::*;
#(
    parameter int          BALL_SIZE  = 8,
    parameter int          BALL_STEP  = 2,
    parameter logic [11:0] BALL_COLOR = COLOR_WHITE,
    parameter int          LIVES      = 3
) (
    input  logic        clk,
    input  logic        rstn,
    ball_ctrl_if.slave  bus
);
    localparam logic [10:0] TRACK_DX = 11'(PADDLE_WIDTH / 2 - BALL_SIZE / 2);
    localparam logic [10:0] SIZE     = 11'(BALL_SIZE);

    ball_state_t state_r, nxt_state_s;
    logic [1:0]  lives_r, nxt_lives_s;
    logic        dx_r, nxt_dx_s, dy_r, nxt_dy_s;
    logic [9:0]  ball_x_r, nxt_ball_x_s, ball_y_r, nxt_ball_y_s;
    logic        miss_r, nxt_miss_s, game_over_r, nxt_game_over_s;
    logic [10:0] track_x_s, track_y_s;
    logic [2:0]  step_s;
    logic [9:0]  calc_x_s, calc_y_s;
    logic        calc_dx_s, calc_dy_s, calc_hit_s, calc_miss_s;
    logic        unused_track_s;

    assign track_x_s      = {1'b0, bus.paddle_x} + TRACK_DX;
    assign track_y_s      = {1'b0, bus.paddle_y} - SIZE;
    assign unused_track_s = &{1'b0, track_x_s[10], track_y_s[10]};

    ball_step_calc #(.BALL_SIZE(BALL_SIZE)) u_calc (
        .ball_x   (ball_x_r),
        .ball_y   (ball_y_r),
        .dx       (dx_r),
        .dy       (dy_r),
        .paddle_x (bus.paddle_x),
        .paddle_y (bus.paddle_y),
        .step     (step_s),
        .nxt_x    (calc_x_s),
        .nxt_y    (calc_y_s),
        .nxt_dx   (calc_dx_s),
        .nxt_dy   (calc_dy_s),
        .hit      (calc_hit_s),
        .miss     (calc_miss_s)
    );

    // Next-state and register-next logic for the ball FSM.
    always_comb begin
        nxt_state_s  = state_r;
        nxt_lives_s  = lives_r;
        nxt_dx_s     = dx_r;
        nxt_dy_s     = dy_r;
        nxt_ball_x_s = ball_x_r;
        nxt_ball_y_s = ball_y_r;
        nxt_miss_s   = 1'b0;
        case (state_r)
            SERVE: begin
                nxt_ball_x_s = track_x_s[9:0];
                nxt_ball_y_s = track_y_s[9:0];
                if (bus.launch) begin
                    nxt_state_s = MOVE;
                    nxt_dx_s    = 1'b1;
                    nxt_dy_s    = 1'b0;
                end else begin
                    nxt_state_s = SERVE;
                end
            end
            MOVE: begin
                if (bus.refr_tick && calc_miss_s) begin
                    nxt_miss_s  = 1'b1;
                    nxt_lives_s = lives_r - 2'd1;
                    nxt_state_s = (lives_r == 2'd1) ? OVER : SERVE;
                end else if (bus.refr_tick) begin
                    nxt_ball_x_s = calc_x_s;
                    nxt_ball_y_s = calc_y_s;
                    nxt_dx_s     = calc_dx_s;
                    nxt_dy_s     = calc_dy_s;
                end else begin
                    nxt_state_s = MOVE;
                end
            end
            OVER: begin
                if (bus.launch) begin
                    nxt_lives_s = 2'(LIVES);
                    nxt_state_s = SERVE;
                end else begin
                    nxt_state_s = OVER;
                end
            end
            default: nxt_state_s = SERVE;
        endcase
        nxt_game_over_s = (nxt_state_s == OVER);
    end

    // FSM and ball registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r     <= SERVE;
            lives_r     <= 2'(LIVES);
            dx_r        <= 1'b1;
            dy_r        <= 1'b0;
            ball_x_r    <= track_x_s[9:0];
            ball_y_r    <= track_y_s[9:0];
            miss_r      <= 1'b0;
            game_over_r <= 1'b0;
        end else begin
            state_r     <= nxt_state_s;
            lives_r     <= nxt_lives_s;
            dx_r        <= nxt_dx_s;
            dy_r        <= nxt_dy_s;
            ball_x_r    <= nxt_ball_x_s;
            ball_y_r    <= nxt_ball_y_s;
            miss_r      <= nxt_miss_s;
            game_over_r <= nxt_game_over_s;
        end
    end

`ifdef BALL_SPEEDUP_EN
    logic [2:0] step_r, nxt_step_s;
    logic [1:0] hits_r, nxt_hits_s;

    // Hit counter and speed step; both restart whenever a new serve begins.
    always_comb begin
        nxt_step_s = step_r;
        nxt_hits_s = hits_r;
        if ((nxt_state_s == SERVE) && (state_r != SERVE)) begin
            nxt_step_s = 3'(BALL_STEP);
            nxt_hits_s = 2'd0;
        end else if ((state_r == MOVE) && bus.refr_tick && calc_hit_s) begin
            nxt_hits_s = hits_r + 2'd1;
            if ((hits_r == 2'd3) && (step_r < 3'd4)) begin
                nxt_step_s = step_r + 3'd1;
            end else begin
                nxt_step_s = step_r;
            end
        end else begin
            nxt_hits_s = hits_r;
        end
    end

    // Speed-up registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            step_r <= 3'(BALL_STEP);
            hits_r <= 2'd0;
        end else begin
            step_r <= nxt_step_s;
            hits_r <= nxt_hits_s;
        end
    end

    assign step_s = step_r;
`else
    logic unused_hit_s;
    assign unused_hit_s = calc_hit_s;
    assign step_s       = 3'(BALL_STEP);
`endif

    assign bus.ball_rgb  = BALL_COLOR;
    assign bus.ball_on   = (state_r != OVER)
                           && in_span(bus.x, ball_x_r, SIZE)
                           && in_span(bus.y, ball_y_r, SIZE);
    assign bus.ball_x    = ball_x_r;
    assign bus.ball_y    = ball_y_r;
    assign bus.miss      = miss_r;
    assign bus.lives     = lives_r;
    assign bus.game_over = game_over_r;
endmodule

// File: tb/tb_ball_ctrl.sv
// Self-checking bench for ball_ctrl: per-tick scoreboard fed by a reference model.
module tb_ball_ctrl;
    import pong_pkg::*;

    localparam int BSZ  = 8;
    localparam int STEP = 2;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    ball_ctrl_if bus ();
    ball_ctrl dut (.clk(clk), .rstn(rstn), .bus(bus));

    typedef struct {
        int x;
        int y;
        bit miss;
        int lives;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_x, m_y, m_lives, p_x, p_y;
    bit   m_dx, m_dy, got_miss;

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_paddle(input int px, input int py);
        p_x = px;
        p_y = py;
        bus.paddle_x = 10'(px);
        bus.paddle_y = 10'(py);
    endtask

    task automatic model_serve();
        m_x  = p_x + PADDLE_WIDTH / 2 - BSZ / 2;
        m_y  = p_y - BSZ;
        m_dx = 1'b1;
        m_dy = 1'b0;
    endtask

    task automatic do_launch();
        bus.launch = 1'b1;
        clk_step();
        bus.launch = 1'b0;
        model_serve();
    endtask

    // Reference motion for one tick in MOVE; result goes to the scoreboard.
    task automatic model_tick();
        int nx, ny;
        bit ndx, ndy, hit, mis;
        exp_t e;
        nx = m_x; ny = m_y; ndx = m_dx; ndy = m_dy; mis = 1'b0;
        if (m_dx) begin
            if (m_x >= MAX_X - BSZ - STEP) begin nx = MAX_X - BSZ; ndx = 1'b0; end
            else nx = m_x + STEP;
        end else begin
            if (m_x <= STEP) begin nx = 0; ndx = 1'b1; end
            else nx = m_x - STEP;
        end
        if (!m_dy) begin
            if (m_y <= STEP) begin ny = 0; ndy = 1'b1; end
            else ny = m_y - STEP;
        end else begin
            hit = (m_y + BSZ >= p_y) && (m_y + BSZ <= p_y + PADDLE_HEIGHT)
                  && (m_x + BSZ > p_x) && (m_x < p_x + PADDLE_WIDTH);
            if (hit) begin ny = p_y - BSZ; ndy = 1'b0; end
            else if (m_y >= MAX_Y - BSZ) mis = 1'b1;
            else ny = m_y + STEP;
        end
        if (mis) m_lives = m_lives - 1;
        else begin m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy; end
        e = '{x: m_x, y: m_y, miss: mis, lives: m_lives};
        sb_q.push_back(e);
    endtask

    task automatic run_tick();
        exp_t e;
        model_tick();
        bus.refr_tick = 1'b1;
        clk_step();
        bus.refr_tick = 1'b0;
        e = sb_q.pop_front();
        got_miss = e.miss;
        n_cmp++;
        if (bus.miss !== e.miss) begin
            n_err++;
            $display("FAIL tick_miss: got %0b expected %0b", bus.miss, e.miss);
        end
        n_cmp++;
        if (bus.lives !== 2'(e.lives)) begin
            n_err++;
            $display("FAIL tick_lives: got %0d expected %0d", bus.lives, e.lives);
        end
        if (!e.miss) begin
            n_cmp++;
            if (bus.ball_x !== 10'(e.x) || bus.ball_y !== 10'(e.y)) begin
                n_err++;
                $display("FAIL tick_pos: got (%0d,%0d) expected (%0d,%0d)",
                         bus.ball_x, bus.ball_y, e.x, e.y);
            end
        end
        clk_step();
        n_cmp++;
        if (bus.miss !== 1'b0) begin
            n_err++;
            $display("FAIL miss_pulse: got %0b expected 0", bus.miss);
        end
    endtask

    task automatic test_reset();
        set_paddle(290, 450);
        rstn = 1'b0;
        clk_step(); clk_step();
        rstn = 1'b1;
        clk_step();
        m_lives = 3;
        n_cmp++;
        if (bus.ball_x !== 10'd336 || bus.ball_y !== 10'd442) begin
            n_err++;
            $display("FAIL reset_pos: got (%0d,%0d) expected (336,442)", bus.ball_x, bus.ball_y);
        end
        n_cmp++;
        if (bus.lives !== 2'd3 || bus.miss !== 1'b0 || bus.game_over !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got lives=%0d miss=%0b over=%0b expected 3/0/0",
                     bus.lives, bus.miss, bus.game_over);
        end
        n_cmp++;
        if (bus.ball_rgb !== 12'hFFF) begin
            n_err++;
            $display("FAIL rgb: got %h expected fff", bus.ball_rgb);
        end
        set_paddle(300, 450);
        clk_step();
        n_cmp++;
        if (bus.ball_x !== 10'd346) begin
            n_err++;
            $display("FAIL serve_track: got %0d expected 346", bus.ball_x);
        end
    endtask

    task automatic test_ball_on();
        int px[5] = '{346, 353, 354, 346, 345};
        int py[5] = '{442, 449, 442, 450, 445};
        bit want[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            bus.x = 10'(px[i]);
            bus.y = 10'(py[i]);
            #1;
            n_cmp++;
            if (bus.ball_on !== want[i]) begin
                n_err++;
                $display("FAIL ball_on(%0d,%0d): got %0b expected %0b", px[i], py[i], bus.ball_on, want[i]);
            end
        end
    endtask

    task automatic test_launch_motion();
        set_paddle(290, 450);
        clk_step();
        do_launch();
        for (int i = 0; i < 4; i++) run_tick();
        for (int i = 0; i < 3; i++) clk_step();
        n_cmp++;
        if (bus.ball_x !== 10'd344 || bus.ball_y !== 10'd434) begin
            n_err++;
            $display("FAIL launch_4ticks: got (%0d,%0d) expected (344,434)", bus.ball_x, bus.ball_y);
        end
    endtask

    task automatic test_walls();
        set_paddle(585, 9);
        rstn = 1'b0;
        clk_step();
        rstn = 1'b1;
        m_lives = 3;
        do_launch();
        run_tick();
        n_cmp++;
        if (bus.ball_x !== 10'd632 || bus.ball_y !== 10'd0) begin
            n_err++;
            $display("FAIL wall_bounce: got (%0d,%0d) expected (632,0)", bus.ball_x, bus.ball_y);
        end
        run_tick();
        n_cmp++;
        if (bus.ball_x !== 10'd630 || bus.ball_y !== 10'd2) begin
            n_err++;
            $display("FAIL wall_reverse: got (%0d,%0d) expected (630,2)", bus.ball_x, bus.ball_y);
        end
    endtask

    task automatic test_paddle();
        set_paddle(146, 450);
        for (int k = 0; k < 400 && m_y != 440; k++) run_tick();
        n_cmp++;
        if (bus.ball_x !== 10'd192 || bus.ball_y !== 10'd440) begin
            n_err++;
            $display("FAIL paddle_approach: got (%0d,%0d) expected (192,440)", bus.ball_x, bus.ball_y);
        end
        run_tick();
        run_tick();
        n_cmp++;
        if (bus.ball_y !== 10'd442) begin
            n_err++;
            $display("FAIL paddle_hit: got y=%0d expected 442", bus.ball_y);
        end
        run_tick();
        n_cmp++;
        if (bus.ball_y !== 10'd440) begin
            n_err++;
            $display("FAIL paddle_rebound: got y=%0d expected 440", bus.ball_y);
        end
    endtask

    task automatic play_to_miss();
        got_miss = 1'b0;
        for (int k = 0; k < 1000 && !got_miss; k++) run_tick();
        n_cmp++;
        if (!got_miss) begin
            n_err++;
            $display("FAIL miss_timeout: got no miss expected one");
        end
    endtask

    task automatic test_miss_serve();
        set_paddle(0, 450);
        play_to_miss();
        clk_step();
        n_cmp++;
        if (bus.lives !== 2'd2 || bus.game_over !== 1'b0 || bus.ball_x !== 10'd46 || bus.ball_y !== 10'd442) begin
            n_err++;
            $display("FAIL miss_serve: got lives=%0d over=%0b (%0d,%0d) expected 2/0 (46,442)",
                     bus.lives, bus.game_over, bus.ball_x, bus.ball_y);
        end
    endtask

    task automatic test_reset_mid_move();
        set_paddle(454, 9);
        clk_step();
        do_launch();
        run_tick();
        run_tick();
        set_paddle(100, 200);
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (bus.ball_x !== 10'd504 || bus.lives !== 2'd2) begin
            n_err++;
            $display("FAIL reset_sync: got x=%0d lives=%0d expected 504/2", bus.ball_x, bus.lives);
        end
        clk_step();
        n_cmp++;
        if (bus.ball_x !== 10'd146 || bus.ball_y !== 10'd192 || bus.lives !== 2'd3) begin
            n_err++;
            $display("FAIL reset_mid_move: got (%0d,%0d) lives=%0d expected (146,192) 3",
                     bus.ball_x, bus.ball_y, bus.lives);
        end
        rstn = 1'b1;
        m_lives = 3;
        bus.refr_tick = 1'b1;
        clk_step();
        bus.refr_tick = 1'b0;
        n_cmp++;
        if (bus.ball_x !== 10'd146 || bus.ball_y !== 10'd192) begin
            n_err++;
            $display("FAIL serve_no_motion: got (%0d,%0d) expected (146,192)", bus.ball_x, bus.ball_y);
        end
    endtask

    task automatic test_game_over();
        for (int r = 0; r < 3; r++) begin
            set_paddle(454, 9);
            clk_step();
            do_launch();
            set_paddle(0, 450);
            play_to_miss();
            n_cmp++;
            if (bus.lives !== 2'(2 - r)) begin
                n_err++;
                $display("FAIL lives_round%0d: got %0d expected %0d", r, bus.lives, 2 - r);
            end
        end
        bus.x = 10'(m_x);
        bus.y = 10'(m_y);
        bus.refr_tick = 1'b1;
        clk_step();
        bus.refr_tick = 1'b0;
        n_cmp++;
        if (bus.game_over !== 1'b1 || bus.ball_on !== 1'b0 || bus.miss !== 1'b0 || bus.lives !== 2'd0) begin
            n_err++;
            $display("FAIL over_state: got over=%0b on=%0b miss=%0b lives=%0d expected 1/0/0/0",
                     bus.game_over, bus.ball_on, bus.miss, bus.lives);
        end
    endtask

    task automatic test_back_to_back();
        bus.launch = 1'b1;
        clk_step();
        n_cmp++;
        if (bus.lives !== 2'd3 || bus.game_over !== 1'b0) begin
            n_err++;
            $display("FAIL restart: got lives=%0d over=%0b expected 3/0", bus.lives, bus.game_over);
        end
        clk_step();
        bus.launch = 1'b0;
        m_lives = 3;
        model_serve();
        run_tick();
        n_cmp++;
        if (bus.ball_x !== 10'd48 || bus.ball_y !== 10'd440) begin
            n_err++;
            $display("FAIL held_launch_move: got (%0d,%0d) expected (48,440)", bus.ball_x, bus.ball_y);
        end
    endtask

    initial begin
        rstn          = 1'b0;
        bus.refr_tick = 1'b0;
        bus.launch    = 1'b0;
        bus.x         = 10'd0;
        bus.y         = 10'd0;
        set_paddle(290, 450);
        test_reset();
        test_ball_on();
        test_launch_motion();
        test_walls();
        test_paddle();
        test_miss_serve();
        test_reset_mid_move();
        test_game_over();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
